// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode/func constants, multi-cycle FSM state
// encodings, instruction class indices and every datapath mux / ALU /
// extender select encoding. Used by both the single-cycle decoder and the
// multi-cycle controller so the datapath select widths stay identical.
package mips_defs;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Func field IR[5:0], meaningful only with OP_RTYPE
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Multi-cycle FSM states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // One-hot instruction class bit positions
  localparam int CL_ADDU = 0;
  localparam int CL_SUBU = 1;
  localparam int CL_ORI  = 2;
  localparam int CL_LW   = 3;
  localparam int CL_SW   = 4;
  localparam int CL_BEQ  = 5;
  localparam int CL_LUI  = 6;
  localparam int CL_JAL  = 7;
  localparam int CL_JR   = 8;
  localparam int CL_ILL  = 9;
  localparam int CL_W    = 10;

  // Next-PC select
  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JAL    = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;

  // ALU operation
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_CMP = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  // Register-file write destination
  localparam logic [2:0] DST_RT = 3'b000;
  localparam logic [2:0] DST_RD = 3'b001;
  localparam logic [2:0] DST_RA = 3'b010;

  // ALU operand selects
  localparam logic [1:0] SRCA_RS  = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [2:0] SRCB_RT  = 3'b000;
  localparam logic [2:0] SRCB_IMM = 3'b001;
  localparam logic [2:0] SRCB_4   = 3'b010;

  // Immediate extender
  localparam logic [2:0] EXT_ZERO = 3'b000;
  localparam logic [2:0] EXT_SIGN = 3'b001;
  localparam logic [2:0] EXT_HI   = 3'b010;

  // Register write-back source
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier.
//   opcode      in  6   IR[31:26]
//   func        in  6   IR[5:0]
//   instr_class out 10  one-hot class (bit positions CL_* in mips_defs);
//                       CL_ILL is set for anything unsupported, including an
//                       R-type with an unlisted func.
module instr_decode
  import mips_defs::*;
(
  input  logic [5:0]      opcode,
  input  logic [5:0]      func,
  output logic [CL_W-1:0] instr_class
);

  always_comb begin
    instr_class = '0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: instr_class[CL_ADDU] = 1'b1;
          FN_SUBU: instr_class[CL_SUBU] = 1'b1;
          FN_JR:   instr_class[CL_JR]   = 1'b1;
          default: instr_class[CL_ILL]  = 1'b1;
        endcase
      end
      OP_ORI:  instr_class[CL_ORI] = 1'b1;
      OP_LW:   instr_class[CL_LW]  = 1'b1;
      OP_SW:   instr_class[CL_SW]  = 1'b1;
      OP_BEQ:  instr_class[CL_BEQ] = 1'b1;
      OP_LUI:  instr_class[CL_LUI] = 1'b1;
      OP_JAL:  instr_class[CL_JAL] = 1'b1;
      default: instr_class[CL_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS controller: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk, reset_n           clock, synchronous active-low reset
//   Opcode, Func           instruction fields, sampled in DECODE only
//   mem_ready / mem_req    memory handshake
//   PCWrite, PCWriteCond, IRWrite, nPC_sel        PC / IR control
//   ALUop, ALUSrcA, ALUSrcB, Extop                ALU and extender selects
//   RegDst, RegWrite, MemWrite, MemorALU          register / memory control
//   illegal, instr_done    one-cycle status pulses
//   state_dbg              current FSM state (forced 0 during reset)
//
// Memory handshake: mem_req is raised in FETCH and MEM and stays high until
// mem_ready; an access completes in the cycle where both are high, and the
// strobes that commit it (IRWrite/PCWrite, MemWrite) are qualified by
// mem_ready in that same cycle. The memory may hold mem_ready low for any
// number of cycles.
module mc_control
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic [2:0] nPC_sel,
  output logic [3:0] ALUop,
  output logic [2:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] Extop,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] MemorALU,
  output logic       illegal,
  output logic       instr_done,
  output logic [2:0] state_dbg
);

  state_t          state_q, state_d;
  logic [CL_W-1:0] class_q;
  logic [CL_W-1:0] dec_class;

  // ALU / extender selects implied by the latched class; held from EXEC
  // through MEM and WB so the ALU result stays stable.
  logic [3:0] sel_alu;
  logic [1:0] sel_src_a;
  logic [2:0] sel_src_b;
  logic [2:0] sel_ext;

  instr_decode u_decode (
    .opcode      (Opcode),
    .func        (Func),
    .instr_class (dec_class)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) class_q <= dec_class;
    end
  end

  always_comb begin
    sel_alu   = ALU_ADD;
    sel_src_a = SRCA_RS;
    sel_src_b = SRCB_RT;
    sel_ext   = EXT_ZERO;
    if (class_q[CL_SUBU]) sel_alu = ALU_SUB;
    if (class_q[CL_ORI]) begin
      sel_alu   = ALU_OR;
      sel_src_b = SRCB_IMM;
    end
    if (class_q[CL_LUI]) begin
      sel_alu   = ALU_LUI;
      sel_src_b = SRCB_IMM;
      sel_ext   = EXT_HI;
    end
    if (class_q[CL_LW] || class_q[CL_SW]) begin
      sel_src_b = SRCB_IMM;
      sel_ext   = EXT_SIGN;
    end
    if (class_q[CL_BEQ]) sel_alu = ALU_CMP;
    if (class_q[CL_JAL]) begin
      sel_src_a = SRCA_PC;
      sel_src_b = SRCB_4;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    nPC_sel     = NPC_PC4;
    ALUop       = ALU_ADD;
    RegDst      = DST_RT;
    ALUSrcA     = SRCA_RS;
    ALUSrcB     = SRCB_RT;
    Extop       = EXT_ZERO;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    MemorALU    = WB_ALU;
    illegal     = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        // PC+4 and IR load happen on the same edge the fetch completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (dec_class[CL_ILL]) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        ALUop   = sel_alu;
        ALUSrcA = sel_src_a;
        ALUSrcB = sel_src_b;
        Extop   = sel_ext;
        if (class_q[CL_LW] || class_q[CL_SW]) begin
          state_d = ST_MEM;
        end else if (class_q[CL_BEQ]) begin
          PCWriteCond = 1'b1;
          nPC_sel     = NPC_BRANCH;
          instr_done  = 1'b1;
          state_d     = ST_FETCH;
        end else if (class_q[CL_JAL]) begin
          RegDst     = DST_RA;
          RegWrite   = 1'b1;
          PCWrite    = 1'b1;
          nPC_sel    = NPC_JAL;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (class_q[CL_JR]) begin
          PCWrite    = 1'b1;
          nPC_sel    = NPC_JR;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (class_q[CL_ADDU] || class_q[CL_SUBU] ||
                     class_q[CL_ORI]  || class_q[CL_LUI]) begin
          state_d = ST_WB;
        end else begin
          // No valid class latched; restart cleanly.
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        ALUop   = sel_alu;
        ALUSrcA = sel_src_a;
        ALUSrcB = sel_src_b;
        Extop   = sel_ext;
        if (class_q[CL_SW]) begin
          MemWrite   = mem_ready;
          instr_done = mem_ready;
          if (mem_ready) state_d = ST_FETCH;
        end else if (mem_ready) begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        ALUop      = sel_alu;
        ALUSrcA    = sel_src_a;
        ALUSrcB    = sel_src_b;
        Extop      = sel_ext;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        RegDst     = (class_q[CL_ADDU] || class_q[CL_SUBU]) ? DST_RD : DST_RT;
        MemorALU   = class_q[CL_LW] ? WB_MEM : WB_ALU;
        state_d    = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset silences every output immediately, abandoning any pending access.
    if (!reset_n) begin
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      nPC_sel     = '0;
      ALUop       = '0;
      RegDst      = '0;
      ALUSrcA     = '0;
      ALUSrcB     = '0;
      Extop       = '0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemorALU    = '0;
      illegal     = 1'b0;
      instr_done  = 1'b0;
    end
  end

  assign state_dbg = reset_n ? state_q : 3'd0;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] Opcode;
  logic [5:0] Func;
  logic       mem_ready;
  logic       mem_req, PCWrite, PCWriteCond, IRWrite;
  logic [2:0] nPC_sel;
  logic [3:0] ALUop;
  logic [2:0] RegDst;
  logic [1:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] Extop;
  logic       RegWrite, MemWrite;
  logic [1:0] MemorALU;
  logic       illegal, instr_done;
  logic [2:0] state_dbg;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       pc_write;
    logic       pc_cond;
    logic       ir_write;
    logic [2:0] npc;
    logic [3:0] alu;
    logic [2:0] dst;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [2:0] ext;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       done;
  } out_t;

  out_t obs;
  assign obs = {state_dbg, mem_req, PCWrite, PCWriteCond, IRWrite, nPC_sel,
                ALUop, RegDst, ALUSrcA, ALUSrcB, Extop, RegWrite, MemWrite,
                MemorALU, illegal, instr_done};

  int vectors;
  int miscompares;

  mc_control dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Opcode      (Opcode),
    .Func        (Func),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .nPC_sel     (nPC_sel),
    .ALUop       (ALUop),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .Extop       (Extop),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .MemorALU    (MemorALU),
    .illegal     (illegal),
    .instr_done  (instr_done),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builders (hand encodings, independent of the RTL package)
  function automatic out_t f_fetch(input logic rdy);
    out_t e = '0;
    e.st = 3'd0; e.mem_req = 1'b1; e.pc_write = rdy; e.ir_write = rdy;
    return e;
  endfunction

  function automatic out_t f_dec(input logic ill);
    out_t e = '0;
    e.st = 3'd1; e.illegal = ill; e.done = ill;
    return e;
  endfunction

  function automatic out_t f_sel(input logic [2:0] st, input logic [3:0] alu,
                                 input logic [1:0] src_a, input logic [2:0] src_b,
                                 input logic [2:0] ext);
    out_t e = '0;
    e.st = st; e.alu = alu; e.src_a = src_a; e.src_b = src_b; e.ext = ext;
    return e;
  endfunction

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; Opcode = 6'b100011; Func = 6'b0;
    next_cycle();
    next_cycle();
    #2;
    vectors++;
    if (obs !== out_t'(0)) begin
      $display("FAIL reset_outputs: got %h expected %h", obs, out_t'(0));
      miscompares++;
    end
    next_cycle();
    reset_n = 1'b1; mem_ready = 1'b0;
    #2;
    vectors++;
    if (obs !== f_fetch(1'b0)) begin
      $display("FAIL reset_release_fetch: got %h expected %h", obs, f_fetch(1'b0));
      miscompares++;
    end
    next_cycle();
  endtask

  // addu; Opcode is switched to lw after DECODE and must be ignored.
  task automatic test_addu();
    out_t e[4];
    e[0] = f_fetch(1'b1);
    e[1] = f_dec(1'b0);
    e[2] = f_sel(3'd2, 4'b0000, 2'b00, 3'b000, 3'b000);
    e[3] = f_sel(3'd4, 4'b0000, 2'b00, 3'b000, 3'b000);
    e[3].reg_write = 1'b1; e[3].dst = 3'b001; e[3].done = 1'b1;
    Opcode = 6'b000000; Func = 6'b100001; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) Opcode = 6'b100011;
      #2;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL addu cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_stall();
    out_t e[8];
    logic rdy[8];
    int ir_pulses;
    ir_pulses = 0;
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    e[0] = f_fetch(1'b0);
    e[1] = f_fetch(1'b0);
    e[2] = f_fetch(1'b1);
    e[3] = f_dec(1'b0);
    e[4] = f_sel(3'd2, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[5] = f_sel(3'd3, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[5].mem_req = 1'b1;
    e[6] = e[5];
    e[7] = f_sel(3'd4, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[7].reg_write = 1'b1; e[7].wb_sel = 2'b01; e[7].done = 1'b1;
    Opcode = 6'b100011; Func = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #2;
      if (IRWrite === 1'b1) ir_pulses++;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL lw_stall cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      next_cycle();
    end
    vectors++;
    if (ir_pulses != 1) begin
      $display("FAIL lw_irwrite_count: got %0d expected 1", ir_pulses);
      miscompares++;
    end
  endtask

  task automatic test_beq();
    out_t e[4];
    e[0] = f_fetch(1'b1);
    e[1] = f_dec(1'b0);
    e[2] = f_sel(3'd2, 4'b0011, 2'b00, 3'b000, 3'b000);
    e[2].pc_cond = 1'b1; e[2].npc = 3'b001; e[2].done = 1'b1;
    e[3] = f_fetch(1'b1);
    Opcode = 6'b000100; Func = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL beq cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      if (i == 2) Opcode = 6'b000011;  // jal follows; fetched next cycle
      next_cycle();
    end
  endtask

  // beq left the FSM one cycle into fetching jal; finish jal, then jr.
  task automatic test_jal_jr();
    out_t e[5];
    logic [5:0] op[5];
    logic [5:0] fn[5];
    e[0] = f_dec(1'b0);
    e[1] = f_sel(3'd2, 4'b0000, 2'b01, 3'b010, 3'b000);
    e[1].dst = 3'b010; e[1].reg_write = 1'b1; e[1].pc_write = 1'b1;
    e[1].npc = 3'b010; e[1].done = 1'b1;
    e[2] = f_fetch(1'b1);
    e[3] = f_dec(1'b0);
    e[4] = f_sel(3'd2, 4'b0000, 2'b00, 3'b000, 3'b000);
    e[4].pc_write = 1'b1; e[4].npc = 3'b011; e[4].done = 1'b1;
    op = '{6'b000011, 6'b000011, 6'b000000, 6'b000000, 6'b000000};
    fn = '{6'b000000, 6'b000000, 6'b001000, 6'b001000, 6'b001000};
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Opcode = op[i]; Func = fn[i];
      #2;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL jal_jr cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    out_t e[3];
    e[0] = f_fetch(1'b1);
    e[1] = f_dec(1'b1);
    e[2] = f_fetch(1'b0);
    Opcode = 6'b111111; Func = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 0);
      #2;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      next_cycle();
    end
  endtask

  // ori, lui, subu, sw and an unsupported R-type func, all back to back.
  task automatic test_back_to_back();
    out_t e[18];
    logic [5:0] op[18];
    logic [5:0] fn[18];
    e[0]  = f_fetch(1'b1);
    e[1]  = f_dec(1'b0);
    e[2]  = f_sel(3'd2, 4'b0010, 2'b00, 3'b001, 3'b000);
    e[3]  = f_sel(3'd4, 4'b0010, 2'b00, 3'b001, 3'b000);
    e[3].reg_write = 1'b1; e[3].done = 1'b1;
    e[4]  = f_fetch(1'b1);
    e[5]  = f_dec(1'b0);
    e[6]  = f_sel(3'd2, 4'b1111, 2'b00, 3'b001, 3'b010);
    e[7]  = f_sel(3'd4, 4'b1111, 2'b00, 3'b001, 3'b010);
    e[7].reg_write = 1'b1; e[7].done = 1'b1;
    e[8]  = f_fetch(1'b1);
    e[9]  = f_dec(1'b0);
    e[10] = f_sel(3'd2, 4'b0001, 2'b00, 3'b000, 3'b000);
    e[11] = f_sel(3'd4, 4'b0001, 2'b00, 3'b000, 3'b000);
    e[11].reg_write = 1'b1; e[11].dst = 3'b001; e[11].done = 1'b1;
    e[12] = f_fetch(1'b1);
    e[13] = f_dec(1'b0);
    e[14] = f_sel(3'd2, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[15] = f_sel(3'd3, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[15].mem_req = 1'b1; e[15].mem_write = 1'b1; e[15].done = 1'b1;
    e[16] = f_fetch(1'b1);
    e[17] = f_dec(1'b1);
    for (int i = 0; i < 18; i++) begin
      case (i / 4)
        0:       begin op[i] = 6'b001101; fn[i] = 6'b000000; end
        1:       begin op[i] = 6'b001111; fn[i] = 6'b000000; end
        2:       begin op[i] = 6'b000000; fn[i] = 6'b100011; end
        3:       begin op[i] = 6'b101011; fn[i] = 6'b000000; end
        default: begin op[i] = 6'b000000; fn[i] = 6'b100000; end
      endcase
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      Opcode = op[i]; Func = fn[i];
      #2;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL back_to_back cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      next_cycle();
    end
  endtask

  // sw stalled in MEM, then reset arrives while memory becomes ready.
  task automatic test_reset_mid_sw();
    out_t e[6];
    logic rdy[6];
    logic rst[6];
    int writes;
    writes = 0;
    e[0] = f_fetch(1'b1);
    e[1] = f_dec(1'b0);
    e[2] = f_sel(3'd2, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[3] = f_sel(3'd3, 4'b0000, 2'b00, 3'b001, 3'b001);
    e[3].mem_req = 1'b1;
    e[4] = '0;
    e[5] = f_fetch(1'b0);
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    rst = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    Opcode = 6'b101011; Func = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i]; reset_n = rst[i];
      #2;
      if (MemWrite === 1'b1) writes++;
      vectors++;
      if (obs !== e[i]) begin
        $display("FAIL reset_mid_sw cyc%0d: got %h expected %h", i, obs, e[i]);
        miscompares++;
      end
      next_cycle();
    end
    vectors++;
    if (writes != 0) begin
      $display("FAIL reset_mid_sw_memwrite: got %0d pulses expected 0", writes);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    mem_ready = 1'b0;
    Opcode = '0;
    Func = '0;
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_back_to_back();
    test_reset_mid_sw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
